// File: rtl/alu_run_controller_pkg.sv
// Shared run-controller state encodings, MiniAlu opcode constants and next-state rule.
// Pure definitions: no latency, no backpressure.
package alu_run_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } runState_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_BEQ = 4'h7;

    // Everything the sequencer looks at in one cycle to choose its next state.
    typedef struct packed {
        logic run;
        logic halt;
        logic stepEdge;
        logic restart;
        logic breakMatch;
    } runCmd_t;

    function automatic runState_t nextRunState(input runState_t cur, input runCmd_t cmd);
        runState_t nxt;
        nxt = cur;
        unique case (cur)
            ST_IDLE: begin
                if (cmd.run)           nxt = ST_RUN;
                else if (cmd.stepEdge) nxt = ST_STEP;
            end
            ST_RUN: begin
                // Dropping run alone never stops the core; only halt or a breakpoint does.
                if (cmd.halt || cmd.breakMatch) nxt = ST_HALT;
            end
            ST_HALT: begin
                if (cmd.restart)                nxt = ST_IDLE;
                else if (cmd.run && !cmd.halt)  nxt = ST_RUN;
                else if (cmd.stepEdge)          nxt = ST_STEP;
            end
            ST_STEP: nxt = ST_HALT;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_run_controller_edge.sv
// Rising-edge detector: registers the input and emits a one-cycle pulse on 0->1.
// Pulse is combinational in the cycle the input first goes high; no backpressure.
module rising_edge_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic iSig,
    output logic oEdge
);

    logic sigQ;

    always_ff @(posedge Clock) begin
        if (Reset) sigQ <= 1'b0;
        else       sigQ <= iSig;
    end

    assign oEdge = iSig & ~sigQ;

endmodule

// File: rtl/alu_run_controller.sv
// Run/halt/single-step sequencer gating MiniAlu enable/reset; optional breakpoint via ALU_RUN_CTRL_BREAKPOINT_EN.
// State changes one cycle after the request; oCoreEnable drops combinationally on a breakpoint hit.
// No backpressure: button/switch levels are sampled every cycle.
module alu_run_controller #(
    parameter int IP_WIDTH    = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iRun,
    input  logic                   iHalt,
    input  logic                   iStep,
    input  logic                   iRestart,
    input  logic [IP_WIDTH-1:0]    iIP,
    input  logic [IP_WIDTH-1:0]    iBreakAddr,
    output logic                   oCoreEnable,
    output logic                   oCoreReset,
    output logic [1:0]             oState,
    output logic [COUNT_WIDTH-1:0] oExecCount,
    output logic                   oBreakHit
);
    import alu_run_controller_pkg::*;

    runState_t               state;
    runState_t               nextState;
    runCmd_t                 cmd;
    logic                    stepEdge;
    logic                    breakMatch;
    logic                    coreResetQ;
    logic [COUNT_WIDTH-1:0]  execCount;

    rising_edge_detect uStepEdge (
        .Clock (Clock),
        .Reset (Reset),
        .iSig  (iStep),
        .oEdge (stepEdge)
    );

`ifdef ALU_RUN_CTRL_BREAKPOINT_EN
    logic resumeMask;
    logic breakHit;

    // Suppress the match for one cycle after leaving HALT so a resume from the
    // breakpoint address can execute that instruction.
    assign breakMatch = (state == ST_RUN) && (iIP == iBreakAddr) && !resumeMask;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            resumeMask <= 1'b0;
            breakHit   <= 1'b0;
        end else begin
            resumeMask <= (state == ST_HALT) && (nextState == ST_RUN);
            if ((state == ST_HALT) && (nextState != ST_HALT))
                breakHit <= 1'b0;
            else if (breakMatch)
                breakHit <= 1'b1;
        end
    end

    assign oBreakHit = breakHit;
`else
    logic unusedBreakInputs;
    assign unusedBreakInputs = ^{iIP, iBreakAddr};
    assign breakMatch        = 1'b0;
    assign oBreakHit         = 1'b0;
`endif

    always_comb begin
        cmd            = '0;
        cmd.run        = iRun;
        cmd.halt       = iHalt;
        cmd.stepEdge   = stepEdge;
        cmd.restart    = iRestart;
        cmd.breakMatch = breakMatch;
        nextState      = nextRunState(state, cmd);
    end

    // STEP ignores breakpoints; breakMatch is only ever true in RUN.
    assign oCoreEnable = (state == ST_STEP) || ((state == ST_RUN) && !breakMatch);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_IDLE;
            coreResetQ <= 1'b1;
            execCount  <= '0;
        end else begin
            state      <= nextState;
            coreResetQ <= (nextState == ST_IDLE);
            // Clearing on entry keeps the count at zero for every cycle spent in IDLE.
            if (nextState == ST_IDLE)
                execCount <= '0;
            else if (oCoreEnable)
                execCount <= execCount + COUNT_WIDTH'(1);
        end
    end

    assign oCoreReset = coreResetQ;
    assign oState     = state;
    assign oExecCount = execCount;

endmodule

// File: tb/tb_alu_run_controller.sv
// Bench for alu_run_controller: directed vector table, breakpoint sequence, then random vs reference model.
module tb_alu_run_controller;

    localparam int IPW = 16;
    localparam int CW  = 4;
`ifdef ALU_RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic           iRun = 1'b0, iHalt = 1'b0, iStep = 1'b0, iRestart = 1'b0;
    logic [IPW-1:0] iIP = '0;
    logic [IPW-1:0] iBreakAddr = 16'hFFFF;
    logic           oCoreEnable, oCoreReset, oBreakHit;
    logic [1:0]     oState;
    logic [CW-1:0]  oExecCount;

    int vectors = 0;
    int miscompares = 0;

    alu_run_controller #(.IP_WIDTH(IPW), .COUNT_WIDTH(CW)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iRun        (iRun),
        .iHalt       (iHalt),
        .iStep       (iStep),
        .iRestart    (iRestart),
        .iIP         (iIP),
        .iBreakAddr  (iBreakAddr),
        .oCoreEnable (oCoreEnable),
        .oCoreReset  (oCoreReset),
        .oState      (oState),
        .oExecCount  (oExecCount),
        .oBreakHit   (oBreakHit)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic rst, run, halt, step, restart;
        int   st;
        int   cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void addRow(input logic rst, input logic run, input logic halt,
                                   input logic step, input logic restart, input int st, input int cnt);
        vec_t v;
        v.rst = rst; v.run = run; v.halt = halt; v.step = step; v.restart = restart;
        v.st = st; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int st, input bit en, input bit crst,
                         input int cnt, input bit brk);
        vectors++;
        if (int'(oState) != st || oCoreEnable !== en || oCoreReset !== crst ||
            int'(oExecCount) != cnt || oBreakHit !== brk) begin
            miscompares++;
            $display("FAIL %s: got state=%0d en=%0b rst=%0b cnt=%0d brk=%0b, expected state=%0d en=%0b rst=%0b cnt=%0d brk=%0b",
                     name, oState, oCoreEnable, oCoreReset, oExecCount, oBreakHit,
                     st, en, crst, cnt, brk);
        end
    endtask

    // Reference model state
    int mSt, mCnt;
    bit mBrk, mPrev, mMask;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------------- directed table ----------------
        repeat (3) addRow(1, 0, 0, 0, 0, 0, 0);
        repeat (2) addRow(0, 0, 0, 0, 0, 0, 0);
        addRow(0, 1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 9; k++) addRow(0, 0, 0, 0, 0, 1, k);
        addRow(0, 0, 1, 0, 0, 2, 10);
        addRow(0, 0, 0, 0, 0, 2, 10);
        addRow(0, 0, 0, 1, 0, 3, 10);
        addRow(0, 0, 0, 1, 0, 2, 11);
        repeat (3) addRow(0, 0, 0, 1, 0, 2, 11);
        addRow(0, 0, 0, 0, 0, 2, 11);
        addRow(0, 0, 0, 1, 0, 3, 11);
        addRow(0, 0, 0, 0, 0, 2, 12);
        repeat (2) addRow(0, 1, 1, 0, 0, 2, 12);
        addRow(0, 0, 0, 0, 1, 0, 0);
        addRow(0, 0, 0, 0, 0, 0, 0);
        addRow(0, 1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 17; k++) addRow(0, 0, 0, 0, 0, 1, k % 16);
        addRow(0, 0, 1, 0, 0, 2, 2);
        addRow(0, 0, 0, 1, 0, 3, 2);
        addRow(1, 0, 0, 1, 0, 0, 0);
        addRow(0, 0, 0, 0, 0, 0, 0);
        addRow(0, 0, 0, 1, 0, 3, 0);
        addRow(0, 0, 0, 0, 0, 2, 1);
        addRow(0, 0, 0, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            Reset = tbl[i].rst; iRun = tbl[i].run; iHalt = tbl[i].halt;
            iStep = tbl[i].step; iRestart = tbl[i].restart;
            @(posedge Clock); #1;
            check($sformatf("table[%0d]", i), tbl[i].st,
                  (tbl[i].st == 1) || (tbl[i].st == 3), tbl[i].st == 0, tbl[i].cnt, 1'b0);
        end
        Reset = 0; iRun = 0; iHalt = 0; iStep = 0; iRestart = 0;

`ifdef ALU_RUN_CTRL_BREAKPOINT_EN
        // ---------------- breakpoint sequence ----------------
        begin
            int ip;
            bit hit;
            iBreakAddr = 16'h0005;
            ip = 0; hit = 0;
            iIP = '0;
            iRun = 1;
            @(posedge Clock); #1;
            iRun = 0;
            for (int c = 0; c < 20 && !hit; c++) begin
                iIP = IPW'(ip);
                #1;
                check($sformatf("bp_run_ip%0d", ip), 1, ip != 5, 0, ip, 0);
                @(posedge Clock); #1;
                if (ip == 5) hit = 1;
                else ip++;
            end
            if (!hit) begin
                vectors++; miscompares++;
                $display("FAIL bp_timeout: breakpoint never reached, ip=%0d expected 5", ip);
            end
            check("bp_halted", 2, 0, 0, 5, 1);
            iRun = 1;
            @(posedge Clock); #1;
            iRun = 0;
            check("bp_resume_masked", 1, 1, 0, 5, 0);
            @(posedge Clock); #1;
            iIP = 16'd6;
            #1;
            check("bp_resume_progress", 1, 1, 0, 6, 0);
            iBreakAddr = 16'hFFFF;
        end
`endif

        // ---------------- randomized vs reference model ----------------
        Reset = 1; iRun = 0; iHalt = 0; iStep = 0; iRestart = 0; iIP = '0;
        iBreakAddr = 16'h0005;
        @(posedge Clock); #1;
        Reset = 0;
        mSt = 0; mCnt = 0; mBrk = 0; mPrev = 0; mMask = 0;

        for (int c = 0; c < 2500; c++) begin
            bit match, en, edgeS;
            int nxt;
            Reset    = ($urandom_range(0, 99) == 0);
            iRun     = ($urandom_range(0, 7) == 0);
            iHalt    = ($urandom_range(0, 9) == 0);
            iRestart = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) iStep = ~iStep;
            iIP = IPW'($urandom_range(0, 7));
            #1;
            match = BP_EN && (mSt == 1) && (iIP == iBreakAddr) && !mMask;
            en    = ((mSt == 1) && !match) || (mSt == 3);
            check($sformatf("random[%0d]", c), mSt, en, mSt == 0, mCnt, mBrk);

            if (Reset) begin
                mSt = 0; mCnt = 0; mBrk = 0; mPrev = 0; mMask = 0;
            end else begin
                edgeS = iStep && !mPrev;
                mPrev = iStep;
                case (mSt)
                    0: nxt = iRun ? 1 : (edgeS ? 3 : 0);
                    1: nxt = (iHalt || match) ? 2 : 1;
                    2: nxt = iRestart ? 0 : ((iRun && !iHalt) ? 1 : (edgeS ? 3 : 2));
                    default: nxt = 2;
                endcase
                if (mSt == 2 && nxt != 2) mBrk = 0;
                else if (match)           mBrk = 1;
                mCnt  = (nxt == 0) ? 0 : (en ? (mCnt + 1) % 16 : mCnt);
                mMask = (mSt == 2) && (nxt == 1);
                mSt   = nxt;
            end
            @(posedge Clock); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_run_controller.md
Name: alu_run_controller

Overview:
Run/halt/single-step sequencer for the MiniAlu core. It gates the core's instruction-pointer and pipeline-register enable, and holds the core in reset until a run or step is requested. It also counts executed cycles for debug. It sits between the board buttons/switches and the MiniAlu enable and reset inputs.

Parameters:
IP_WIDTH, 16, width of the instruction pointer observed and of the breakpoint address
COUNT_WIDTH, 16, width of the executed-cycle counter

Ports:
Clock  input  1  system clock; all state updates on posedge
Reset  input  1  synchronous, active-high; forces controller to IDLE
iRun  input  1  level; request continuous execution
iHalt  input  1  level; request halt
iStep  input  1  raw step button; rising edge detected internally
iRestart  input  1  level; return to IDLE (core reset) from HALT
iIP  input  IP_WIDTH  current instruction pointer of the core
iBreakAddr  input  IP_WIDTH  breakpoint address (used only with feature)
oCoreEnable  output  1  enable for core IP counter and pipeline flops
oCoreReset  output  1  reset to core; high while in IDLE
oState  output  2  IDLE=0, RUN=1, HALT=2, STEP=3
oExecCount  output  COUNT_WIDTH  cycles with oCoreEnable=1 since leaving IDLE
oBreakHit  output  1  sticky; set when a breakpoint halts the core

Behaviour:
- Clock and reset: single Clock domain; Reset is synchronous and active-high.
- Reset values: state=IDLE, oCoreEnable=0, oCoreReset=1, oExecCount=0, oBreakHit=0, step edge register=0.
- Step edge: stepEdge = iStep & ~iStep_q, where iStep_q is iStep registered. Edge is one cycle wide; a held button produces one step.
- oCoreEnable is combinational from state: 1 in RUN (unless breakpoint match, see feature) and in STEP; 0 otherwise.
- oCoreReset = (state==IDLE).
- IDLE transitions: iRun -> RUN; else stepEdge -> STEP; else stay.
- RUN transitions: iHalt -> HALT; breakpoint match -> HALT; else stay. iRun deasserting alone does not halt.
- HALT transitions, in priority order:
  - iRestart -> IDLE
  - iRun & ~iHalt -> RUN
  - stepEdge -> STEP
  - else stay
- STEP: exactly one cycle with oCoreEnable=1, then unconditionally -> HALT. Inputs are ignored during STEP.
- Simultaneous iRun and iHalt: halt wins in RUN; no transition to RUN from HALT.
- oExecCount:
  - cleared while in IDLE;
  - +1 on each posedge where oCoreEnable=1;
  - wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- oBreakHit: cleared on any exit from HALT; otherwise holds.
- Reset asserted in any state, including mid-STEP: next cycle is IDLE with all reset values.

Optional Feature:
Macro ALU_RUN_CTRL_BREAKPOINT_EN.

With the macro defined:
- In RUN, a match (iIP==iBreakAddr) deasserts oCoreEnable in the same cycle (combinationally), so the instruction at iBreakAddr is not advanced past.
- The match also sets oBreakHit and moves the controller to HALT next cycle.
- Match is masked on the first RUN cycle after HALT, so resuming from a breakpoint makes progress.
- STEP ignores breakpoints.

Without the macro: iBreakAddr is unused, no breakpoint logic is generated, and oBreakHit is tied to 0.

Decomposition:
- Shared definitions include file: state encodings ST_IDLE/ST_RUN/ST_HALT/ST_STEP (2-bit) alongside the existing opcode defines.
- One sub-module: rising_edge_detect (registered input, one-cycle pulse out), used for iStep and reusable for other buttons.
- The counter reuses the existing up-counter style with synchronous clear.

Test Plan:
1. Reset high 3 cycles, then low with all inputs 0 -> oState=0, oCoreReset=1, oCoreEnable=0, oExecCount=0 held.
2. Pulse iRun 1 cycle, wait 10 cycles, assert iHalt -> oState RUN then HALT one cycle after iHalt; oExecCount=number of enabled cycles; oCoreEnable=0 in HALT.
3. From HALT, hold iStep high 5 cycles -> exactly one STEP cycle, oExecCount +1, back to HALT; release and press again -> another +1.
4. From HALT, assert iRun and iHalt together -> stays HALT. Then iRestart=1 -> IDLE, oCoreReset=1, oExecCount=0.
5. (feature) iBreakAddr=0x0005, drive iIP incrementing from 0 in RUN -> oCoreEnable low in the cycle iIP=5, HALT next cycle, oBreakHit=1. iRun again -> resumes, oBreakHit=0.
6. Force oExecCount to 0xFFFF via long RUN (COUNT_WIDTH=4 build: 15 cycles) -> wraps to 0 on next enabled cycle; Reset during STEP -> IDLE next cycle.
